// File: rtl/gesture_classifier.sv
// Motion-vector gesture classifier: qualifies per-strobe direction candidates,
// confirms a run of matching candidates, emits one gesture, then blanks input.
module gesture_classifier #(
  parameter int ACC_SUM_BITS    = 18,
  parameter int ACC_COUNT_BITS  = 12,
  parameter int MIN_EVENTS      = 20,
  parameter int MIN_MAGNITUDE   = 64,
  parameter int DOMINANCE_SHIFT = 1,
  parameter int CONFIRM_COUNT   = 2,
  parameter int COOLDOWN_CYCLES = 1000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic signed [ACC_SUM_BITS-1:0] delta_x,
  input  logic signed [ACC_SUM_BITS-1:0] delta_y,
  input  logic [ACC_SUM_BITS-1:0]        abs_delta_x,
  input  logic [ACC_SUM_BITS-1:0]        abs_delta_y,
  input  logic [ACC_COUNT_BITS-1:0]      total_events,
  output logic                           gesture_valid,
  output logic [1:0]                     gesture_dir,
  output logic                           busy,
  output logic [7:0]                     gesture_count
);

  typedef enum logic [1:0] {IDLE, CONFIRM, COOLDOWN} state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int EXT_W = ACC_SUM_BITS + DOMINANCE_SHIFT;
  localparam int CD_W  = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [3:0]      CONFIRM_N = 4'(CONFIRM_COUNT);
  localparam logic [CD_W-1:0] CD_LOAD   = CD_W'(COOLDOWN_CYCLES - 1);

  // Widened so the shifted minor axis never loses its top bits.
  function automatic logic dominates(input logic [ACC_SUM_BITS-1:0] major,
                                     input logic [ACC_SUM_BITS-1:0] minor);
    logic [EXT_W-1:0] major_ext;
    logic [EXT_W-1:0] minor_ext;
    major_ext = EXT_W'(major);
    minor_ext = EXT_W'(minor) << DOMINANCE_SHIFT;
    return major_ext > minor_ext;
  endfunction

  function automatic logic positive(input logic signed [ACC_SUM_BITS-1:0] v);
    return !v[ACC_SUM_BITS-1] && (v != '0);
  endfunction

  state_t                    state, state_next;
  logic [3:0]                streak;
  logic [1:0]                dir_q;
  logic [CD_W-1:0]           cd_cnt;

  logic                      h_dom_p0, v_dom_p0, cand_p0;
  logic [ACC_SUM_BITS-1:0]   max_mag_p0;
  logic [1:0]                cand_dir_p0;
  logic                      hit, same_dir, emit;
  logic [3:0]                streak_inc;

  // Stage p0: combinational candidate evaluation on the raw inputs
  always_comb begin
    h_dom_p0   = dominates(abs_delta_x, abs_delta_y);
    v_dom_p0   = dominates(abs_delta_y, abs_delta_x);
    max_mag_p0 = (abs_delta_x > abs_delta_y) ? abs_delta_x : abs_delta_y;
    cand_p0    = (total_events >= ACC_COUNT_BITS'(MIN_EVENTS)) &&
                 (max_mag_p0 >= ACC_SUM_BITS'(MIN_MAGNITUDE)) &&
                 (h_dom_p0 || v_dom_p0);
    if (h_dom_p0) cand_dir_p0 = positive(delta_x) ? DIR_RIGHT : DIR_LEFT;
    else          cand_dir_p0 = positive(delta_y) ? DIR_DOWN  : DIR_UP;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (hit) state_next = emit ? COOLDOWN : CONFIRM;
      CONFIRM: begin
        if (in_valid) begin
          if (!cand_p0)  state_next = IDLE;
          else if (emit) state_next = COOLDOWN;
        end
      end
      COOLDOWN: if (cd_cnt == '0) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    hit        = in_valid && cand_p0;
    same_dir   = (cand_dir_p0 == dir_q);
    streak_inc = streak + 4'd1;
    emit       = 1'b0;
    case (state)
      IDLE:    emit = hit && (CONFIRM_N == 4'd1);
      CONFIRM: emit = hit && same_dir && (streak_inc == CONFIRM_N);
      default: emit = 1'b0;
    endcase
    busy = (state == COOLDOWN);
  end

  // Stage p1: registered streak, cooldown timer and emit outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      streak        <= '0;
      cd_cnt        <= '0;
      gesture_valid <= 1'b0;
      gesture_dir   <= DIR_UP;
      gesture_count <= '0;
    end else begin
      gesture_valid <= emit;
      if (emit) begin
        gesture_dir   <= cand_dir_p0;
        gesture_count <= gesture_count + 8'd1;
        cd_cnt        <= CD_LOAD;
        streak        <= '0;
      end else begin
        case (state)
          IDLE: if (hit) begin
            streak <= 4'd1;
            dir_q  <= cand_dir_p0;
          end
          CONFIRM: if (in_valid) begin
            if (!cand_p0) begin
              streak <= '0;
            end else if (same_dir) begin
              streak <= streak_inc;
            end else begin
              streak <= 4'd1;
              dir_q  <= cand_dir_p0;
            end
          end
          COOLDOWN: if (cd_cnt != '0) cd_cnt <= cd_cnt - 1'b1;
          default: streak <= '0;
        endcase
      end
    end
  end

endmodule
